micros_timer: RTL
=================

# micros_timer

Programmable microsecond alarm timer that sits directly downstream of the free-running 32-bit microsecond counter. It consumes the `micros` count and compares it against a software-programmed deadline. On expiry it raises a one-cycle interrupt pulse and sets a sticky status flag. It supports one-shot and drift-free periodic modes through a small 4-register CPU-side interface.

## Interface
Parameters:
- none (fixed 32-bit datapath; clock domain shared with the microsecond counter)

Ports:
- `clk`  in  1  system clock, 100 MHz, same clock as the microsecond counter
- `reset`  in  1  asynchronous, active-low reset
- `micros`  in  32  current microsecond count from the counter; wraps 0xFFFFFFFF→0
- `we`  in  1  register write strobe, one cycle
- `re`  in  1  register read strobe, one cycle
- `addr`  in  2  register select
- `wdata`  in  32  write data
- `rdata`  out  32  read data, registered
- `irq`  out  1  expiry interrupt, one-cycle pulse
- `armed`  out  1  high while the timer is armed

## Operation
Registers:
- 0 INTERVAL (R/W): microsecond delay/period; reset value 0.
- 1 CTRL (R/W): bit0 EN, bit1 PERIODIC; other bits read 0.
  - Writing EN=1 arms or re-arms the timer.
  - Writing EN=0 disarms it.
  - EN reads back as `armed`.
- 2 STATUS: bit0 EXPIRED, sticky.
  - Write 1 to bit0 clears EXPIRED.
  - Writing 0 has no effect.
- 3 REMAINING (RO): `target - micros` while armed and not yet reached; otherwise 0. Writes are ignored.

State machine (IDLE, ARMED):
- IDLE → ARMED on a CTRL write with EN=1: `target <= micros + INTERVAL` (mod 2^32), using the `micros` value sampled on that write edge.
- ARMED, "reached" = bit31 of (`micros - target`) == 0. This is a wrap-safe compare, valid for intervals < 2^31.
- ARMED and reached, one-shot (PERIODIC=0 or INTERVAL=0): `irq <= 1`, `EXPIRED <= 1`, state → IDLE.
- ARMED and reached, PERIODIC=1 and INTERVAL≠0: `irq <= 1`, `EXPIRED <= 1`, `target <= target + INTERVAL` (no cumulative drift), stay ARMED.
- ARMED → ARMED on a CTRL write with EN=1: restart, with `target` recomputed from the current `micros`.
- ARMED → IDLE on a CTRL write with EN=0.
- INTERVAL writes while ARMED do not move the current `target`. They take effect at the next re-arm or periodic reload.

Simultaneous events:
- CTRL write and "reached" on the same edge: the write wins. No `irq` is raised, and the timer is restarted or stopped.
- STATUS clear and expiry on the same edge: set wins, and EXPIRED = 1.
- Periodic reload whose new target is already in the past (e.g. the CPU stalled): fires again on the next edge. Missed periods are not batched.

Reset (`reset` low, asynchronous):
- State IDLE.
- `irq`=0, `armed`=0, `rdata`=0.
- INTERVAL=0, CTRL=0, EXPIRED=0, `target`=0.
- Deassertion of reset mid-operation leaves the block IDLE; software must re-arm.

## Timing
- Arm latency: CTRL write at edge N; `armed`=1 after edge N; compare active from edge N+1.
- Fire latency: if `micros` first equals `target` in the cycle before edge M, then `irq`=1 for exactly the cycle after edge M, and EXPIRED reads 1 from that cycle on.
- INTERVAL=0 armed at edge N: `irq` pulses after edge N+1.
- `irq` is never high for two consecutive cycles, except periodic catch-up, where a pulse per edge is allowed.
- Read: `re` at edge N → `rdata` valid after edge N, holding until the next `re`. REMAINING is sampled at edge N.
- `we` and `re` in the same cycle: `rdata` returns the pre-write value.

## Test plan
- Reset: assert `reset`=0 mid-ARMED → `irq`=0, `armed`=0, `rdata`=0 immediately; all registers read 0 after release.
- One-shot: INTERVAL=5, arm at `micros`=100 → exactly one `irq` pulse, one cycle after `micros`=105; `armed`=0; STATUS=1; write STATUS=1 → STATUS=0.
- Periodic no-drift: INTERVAL=3, PERIODIC=1, arm at `micros`=10 → pulses after `micros`=13, 16, 19, 22. Disarm → no further pulses.
- Wrap-around: arm at `micros`=0xFFFFFFFE with INTERVAL=4 → no early fire; pulse after `micros`=0x00000002. REMAINING reads 4,3,2,1 across the wrap.
- Collisions:
  - CTRL EN=0 written on the reach edge → no `irq`.
  - STATUS clear on the fire edge → STATUS reads 1.
  - Re-arm while ARMED at `micros`=50, INTERVAL=10 → fire after 60, not at the original target.
- INTERVAL=0 armed → single pulse after edge N+1, even with PERIODIC=1; `armed`=0 afterwards.

Source files
------------

// File: rtl/micros_timer.sv
// micros_timer: programmable alarm against the free-running 32-bit
// microsecond count. It supports one-shot and drift-free periodic modes,
// a sticky EXPIRED flag, a one-cycle irq pulse and four CPU registers.
module micros_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] micros,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        armed
);

  localparam logic [1:0] ADDR_INTERVAL  = 2'd0;
  localparam logic [1:0] ADDR_CTRL      = 2'd1;
  localparam logic [1:0] ADDR_STATUS    = 2'd2;
  localparam logic [1:0] ADDR_REMAINING = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] interval_q, interval_d;
  logic [31:0] target_q, target_d;
  logic [31:0] rdata_q, rdata_d;
  logic        periodic_q, periodic_d;
  logic        expired_q, expired_d;
  logic        irq_q, irq_d;

  logic        ctrl_wr;
  logic        interval_wr;
  logic        status_clr;
  logic [31:0] since_target;
  logic        reached;
  logic        reload;
  logic [31:0] remaining;
  logic [31:0] reg_rd;

  // Register write decode.
  assign ctrl_wr     = we && (addr == ADDR_CTRL);
  assign interval_wr = we && (addr == ADDR_INTERVAL);
  assign status_clr  = we && (addr == ADDR_STATUS) && wdata[0];

  // Wrap-safe deadline compare: the target counts as reached once the signed
  // distance micros - target is non-negative. This holds for intervals below 2^31.
  assign since_target = micros - target_q;
  assign reached      = (state_q == ST_ARMED) && !since_target[31];

  // A zero interval would reload onto the same target forever, so it
  // behaves as a one-shot even with PERIODIC set.
  assign reload = periodic_q && (interval_q != 32'd0);

  // Time left before the deadline (target - micros). It reads zero when
  // disarmed or once the deadline has been reached.
  assign remaining = ((state_q == ST_ARMED) && since_target[31])
                     ? (~since_target + 32'd1) : 32'd0;

  // Read mux. It uses only pre-edge state, so a simultaneous write is not
  // visible until a later read.
  always_comb begin
    reg_rd = 32'd0;
    case (addr)
      ADDR_INTERVAL:  reg_rd = interval_q;
      ADDR_CTRL:      reg_rd = {30'd0, periodic_q, (state_q == ST_ARMED)};
      ADDR_STATUS:    reg_rd = {31'd0, expired_q};
      ADDR_REMAINING: reg_rd = remaining;
      default:        reg_rd = 32'd0;
    endcase
  end

  // FSM next state: a CTRL write takes priority over reaching the deadline.
  // Expiry sets EXPIRED after any clear on the same edge.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    irq_d     = 1'b0;
    expired_d = expired_q;
    if (status_clr) begin
      expired_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && wdata[0]) begin
          state_d  = ST_ARMED;
          target_d = micros + interval_q;
        end
      end
      ST_ARMED: begin
        if (ctrl_wr) begin
          if (wdata[0]) begin
            target_d = micros + interval_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (reached) begin
          irq_d     = 1'b1;
          expired_d = 1'b1;
          if (reload) begin
            // Advance from the old target rather than from micros, so
            // periods never accumulate drift.
            target_d = target_q + interval_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register-file next state: INTERVAL and PERIODIC writes, and read capture.
  always_comb begin
    interval_d = interval_q;
    periodic_d = periodic_q;
    rdata_d    = rdata_q;
    if (interval_wr) begin
      interval_d = wdata;
    end
    if (ctrl_wr) begin
      periodic_d = wdata[1];
    end
    if (re) begin
      rdata_d = reg_rd;
    end
  end

  // State and register update, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      interval_q <= 32'd0;
      target_q   <= 32'd0;
      rdata_q    <= 32'd0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      target_q   <= target_d;
      rdata_q    <= rdata_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;
  assign armed = (state_q == ST_ARMED);

endmodule
